// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment decoder for the key/7-seg scanner.
package seg_pkg;

  typedef struct packed {
    logic       valid;
    logic       dot;
    logic [3:0] val;
  } digit_t;

  // Active-high "all segments off"; polarity is applied at the output flop.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser, stability counter,
// active-high debounced level and a one-cycle press pulse.
module key_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          prs_q, prs_d;
  logic          raw_on;

  always_comb begin
    s1_d   = key_raw;
    s2_d   = s1_q;
    raw_on = ~s2_q;
    cnt_d  = '0;
    lvl_d  = lvl_q;
    prs_d  = 1'b0;
    // Any cycle that agrees with the level clears the count.
    if (raw_on != lvl_q) begin
      if (cnt_q == CW'(DEB_CYC)) begin
        lvl_d = raw_on;
        prs_d = raw_on;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      cnt_q <= '0;
      lvl_q <= 1'b0;
      prs_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
    end
  end

  assign level = lvl_q;
  assign press = prs_q;

endmodule

// File: rtl/seg_key_scanner.sv
// Debounced hex entry into an N_DIG shift buffer, time-multiplexed
// onto a common-segment display with run/freeze modes.
module seg_key_scanner
  import seg_pkg::*;
#(
  parameter int F_CLK          = 50_000_000,
  parameter int F_SCAN         = 1_000,
  parameter int N_DIG          = 8,
  parameter int DEB_CYC        = 1_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       key,
  output logic [N_DIG-1:0] cs,
  output logic [7:0]       o_dig_sel,
  output logic [6:0]       key_press,
  output logic             run
);

  localparam int SCAN_DIV = F_CLK / F_SCAN;
  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIG-1:0] CS_OFF =
    SEG_ACTIVE_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  logic [6:0] lvl;
  logic [6:0] prs;

  for (genvar i = 0; i < 7; i++) begin : g_deb
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key[i]),
      .level   (lvl[i]),
      .press   (prs[i])
    );
  end

  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             run_q, run_d;
  logic             strt_q, strt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  digit_t           buf_q [N_DIG];
  digit_t           buf_d [N_DIG];
  logic [N_DIG-1:0] cs_q, cs_d;
  logic [7:0]       seg_q, seg_d;

  logic             tick;
  digit_t           src;
  logic [N_DIG-1:0] cs_on;
  logic [7:0]       seg_on;

  always_comb begin
    tick   = (tcnt_q == TW'(SCAN_DIV - 1));
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    strt_d = strt_q | tick;
    run_d  = run_q ^ prs[6];

    ptr_d = ptr_q;
    if (!run_d) begin
      ptr_d = '0;
    end else if (tick) begin
      ptr_d = (ptr_q == PW'(N_DIG - 1)) ? '0 : ptr_q + 1'b1;
    end

    buf_d = buf_q;
    if (prs[5]) begin
      for (int k = N_DIG - 1; k > 0; k--) begin
        buf_d[k] = buf_q[k-1];
      end
      buf_d[0] = '{valid: 1'b1, dot: lvl[4], val: lvl[3:0]};
    end

    // Frozen mode shows the keys live instead of the buffer.
    if (run_q) begin
      src = buf_q[ptr_q];
    end else begin
      src = '{valid: 1'b1, dot: lvl[4], val: lvl[3:0]};
    end

    cs_on        = '0;
    cs_on[ptr_q] = strt_q;
    seg_on       = SEG_BLANK;
    if (strt_q && src.valid) begin
      seg_on = {src.dot, hex2seg(src.val)};
    end

    cs_d  = SEG_ACTIVE_LOW ? ~cs_on : cs_on;
    seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      run_q  <= 1'b0;
      strt_q <= 1'b0;
      ptr_q  <= '0;
      for (int k = 0; k < N_DIG; k++) begin
        buf_q[k] <= '0;
      end
      cs_q   <= CS_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      tcnt_q <= tcnt_d;
      run_q  <= run_d;
      strt_q <= strt_d;
      ptr_q  <= ptr_d;
      buf_q  <= buf_d;
      cs_q   <= cs_d;
      seg_q  <= seg_d;
    end
  end

  assign cs        = cs_q;
  assign o_dig_sel = seg_q;
  assign key_press = prs;
  assign run       = run_q;

endmodule

// File: tb/tb_seg_key_scanner.sv
// Directed bench for seg_key_scanner: 5 digits, tick every 10 cycles, 4-cycle debounce.
module tb_seg_key_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] key;
  logic [4:0] cs;
  logic [7:0] seg;
  logic [6:0] kp;
  logic       run;

  int n_run  = 0;
  int n_fail = 0;
  int n_load = 0;

  seg_key_scanner #(
    .F_CLK          (1000),
    .F_SCAN         (100),
    .N_DIG          (5),
    .DEB_CYC        (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .cs        (cs),
    .o_dig_sel (seg),
    .key_press (kp),
    .run       (run)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (kp[5] === 1'b1) n_load++;

  typedef struct {
    logic [3:0] nib;
    logic       dot;
    logic [7:0] exp;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int b);
    key[b] = 1'b0;
    cyc(10);
    key[b] = 1'b1;
    cyc(10);
  endtask

  task automatic wait_cs(input logic [4:0] want, input string nm);
    int t;
    t = 0;
    while (cs !== want && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (cs !== want) chk({nm, "_timeout"}, 32'(cs), 32'(want));
  endtask

  task automatic chk_digit(input int d, input logic [7:0] exp,
                           input string nm);
    logic [4:0] want;
    want = ~(5'd1 << d);
    wait_cs(want, nm);
    if (cs === want) chk(nm, 32'(seg), 32'(exp));
  endtask

  initial begin
    tv[0] = '{4'h0, 1'b0, 8'hC0};
    tv[1] = '{4'h1, 1'b0, 8'hF9};
    tv[2] = '{4'h5, 1'b0, 8'h92};
    tv[3] = '{4'h8, 1'b0, 8'h80};
    tv[4] = '{4'hA, 1'b1, 8'h08};
    tv[5] = '{4'hC, 1'b0, 8'hC6};
    tv[6] = '{4'hE, 1'b0, 8'h86};
    tv[7] = '{4'hF, 1'b1, 8'h0E};

    key = 7'h7F;
    rst = 1'b1;
    cyc(3);
    chk("rst_cs", 32'(cs), 32'h1F);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_run", 32'(run), 32'h0);
    chk("rst_kp", 32'(kp), 32'h0);
    rst = 1'b0;
    cyc(5);
    chk("cs_before_tick", 32'(cs), 32'h1F);
    cyc(55);
    chk("idle_cs", 32'(cs), 32'h1E);
    chk("idle_seg", 32'(seg), 32'hC0);
    chk("idle_run", 32'(run), 32'h0);

    // Bounce shorter than the debounce window, then a clean hold.
    for (int i = 0; i < 5; i++) begin
      key[5] = 1'b0;
      cyc(2);
      key[5] = 1'b1;
      cyc(2);
    end
    cyc(10);
    chk("bounce_no_press", n_load, 0);
    key[5] = 1'b0;
    cyc(6);
    chk("press_early", 32'(kp[5]), 32'h0);
    cyc(1);
    chk("press_edge", 32'(kp[5]), 32'h1);
    cyc(1);
    chk("press_one_cycle", 32'(kp[5]), 32'h0);
    key[5] = 1'b1;
    cyc(10);
    chk("press_count", n_load, 1);

    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(15);

    for (int i = 0; i < 8; i++) begin
      key = {2'b11, ~tv[i].dot, ~tv[i].nib};
      cyc(12);
      chk($sformatf("live_seg_%0d", i), 32'(seg), 32'(tv[i].exp));
      chk($sformatf("live_cs_%0d", i), 32'(cs), 32'h1E);
    end

    // Enter 'A' with dot, load it, then start scanning.
    key = {2'b11, 1'b0, 4'h5};
    cyc(12);
    tap(5);
    tap(6);
    key = 7'h7F;
    cyc(12);
    chk("run_on", 32'(run), 32'h1);
    chk_digit(0, 8'h08, "a_dot_d0");
    chk_digit(1, 8'hFF, "blank_d1");
    chk_digit(2, 8'hFF, "blank_d2");
    chk_digit(3, 8'hFF, "blank_d3");
    chk_digit(4, 8'hFF, "blank_d4");

    for (int v = 1; v <= 6; v++) begin
      key[3:0] = ~4'(v);
      cyc(12);
      tap(5);
    end
    chk_digit(0, 8'h82, "ld6_d0");
    chk_digit(1, 8'h92, "ld6_d1");
    chk_digit(2, 8'h99, "ld6_d2");
    chk_digit(3, 8'hB0, "ld6_d3");
    chk_digit(4, 8'hA4, "ld6_d4");

    wait_cs(5'b01111, "wrap_last");
    begin
      int t;
      t = 0;
      while (cs === 5'b01111 && t < 15) begin
        @(negedge clk);
        t++;
      end
    end
    chk("wrap_to_0", 32'(cs), 32'h1E);

    // LOAD and RUN debounced on the same cycle.
    key[3:0] = ~4'h7;
    cyc(12);
    key[6:5] = 2'b00;
    cyc(10);
    key[6:5] = 2'b11;
    cyc(10);
    chk("both_run", 32'(run), 32'h0);
    chk("both_cs", 32'(cs), 32'h1E);
    chk("both_live", 32'(seg), 32'hF8);
    tap(6);
    chk("rerun", 32'(run), 32'h1);
    chk_digit(0, 8'hF8, "both_d0");
    chk_digit(4, 8'hB0, "both_d4");

    wait_cs(5'b10111, "ptr3");
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(cs), 32'h1F);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_run", 32'(run), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    key = 7'h7F;
    cyc(20);
    chk("post_rst_live", 32'(seg), 32'hC0);
    tap(6);
    chk("post_rst_run", 32'(run), 32'h1);
    chk_digit(0, 8'hFF, "post_rst_d0");
    chk_digit(2, 8'hFF, "post_rst_d2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
